decode_stage: RTL
=================

# decode_stage

Registered, flow-controlled RV32I instruction decode stage sitting between fetch and issue. Raw instruction words and their PCs are accepted through a valid/ready port and buffered in a DEPTH-entry queue. Each word is decoded into opcode, register addresses, function fields, XLEN-wide immediate and a one-hot format class, and presented on a registered valid/ready output. Adds buffering, flush, configurable XLEN and optional illegal-instruction detection to the combinational field decode.

## Interface

- XLEN, 32: datapath width, 32 or 64; immediates sign-extended to XLEN.
- DEPTH, 2: input queue entries, power of two, ≥2.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  discard all queued and output-held instructions.
- in_valid  in  1  in_instr/in_pc valid.
- in_ready  out  1  queue can accept; reset 0 while rst_n low, 1 after.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded bundle valid; reset 0.
- out_ready  in  1  consumer accepts bundle.
- out_pc  out  XLEN  PC of bundle; reset 0.
- out_opcode  out  7  instr[6:0]; reset 0.
- out_rd, out_rs1, out_rs2  out  5 each  register addresses; reset 0.
- out_funct3  out  3 / out_funct7  out  7  function fields; reset 0.
- out_imm  out  XLEN  decoded immediate; reset 0.
- out_class  out  6  one-hot {R,I,S,B,U,J}; 0 for unrecognised; reset 0.
- out_illegal  out  1  illegal instruction flag; reset 0.

## Operation

- Format classes by instr[6:2]: R=01100; I=00100,00000,11001,00011,11100; S=01000; B=11000; U=01101,00101; J=11011. instr[1:0]≠11 (compressed) gives class 0.
- Field gating: rd for R/I/U/J; funct3 and rs1 for R/I/S/B; rs2 for R/S/B; funct7 for R only; else 0. opcode always passed.
- Immediate: I {instr[31:20]}; S {31:25,11:7}; B {31,7,30:25,11:8,0}; U {31:12,12'b0} then sign-extended from bit 31 when XLEN=64; J {31,19:12,20,30:21,0}; all sign-extended to XLEN; R and class-0 give 0.
- Queue: circular buffer of {instr,pc}, read/write pointers log2(DEPTH) bits wrapping naturally, count 0..DEPTH.
- in_ready = (count < DEPTH); depends only on registered state, never on out_ready.
- Output register loads decoded head when out_valid=0 or out_ready=1 and a source is available. Source = queue head; if queue empty, input bypasses the queue directly into the output register.
- Push and pop in the same cycle: count unchanged, order preserved.
- Total capacity DEPTH+1 (queue + output register). Strict FIFO order.
- flush: next cycle count=0, pointers=0, out_valid=0; any in_valid handshake in the flush cycle is discarded; out_ready ignored that cycle.

## Timing

- Latency: word accepted at edge N is on the output after edge N (valid in cycle N+1) when pipeline empty; otherwise after all earlier words retire.
- Throughput: one instruction per cycle with out_ready held 1.
- Output bundle stable while out_valid=1 and out_ready=0.
- Asynchronous reset: all state and outputs to reset values immediately; in_ready held 0 during reset, rises the cycle after rst_n deassert. Reset mid-stream drops all contents.

## Configuration

- DECODE_ILLEGAL_CHECK_EN defined: out_illegal=1 for compressed word, unrecognised opcode, R-type funct7 not 0000000/0100000 (0100000 legal only with funct3 000 or 101), load funct3 011/110/111, store funct3 >010, branch funct3 010/011, JALR funct3≠000. Illegal bundles still flow in order; fields decoded normally.
- Undefined: out_illegal constant 0; no check logic synthesised.

## Test plan

- Reset release, push 0x00500093 pc 0x100 -> next cycle out_valid=1, class I, rd=1, rs1=0, imm=5, pc=0x100.
- 0x12345137 -> class U, rd=2, imm=0x12345000; XLEN=64 with 0xFE000EE3 (beq x0,x0,-4) -> class B, imm=0xFFFF_FFFF_FFFF_FFFC, rd=0.
- out_ready=0, push DEPTH+1 words -> in_ready falls after DEPTH queue entries plus output filled; release out_ready -> all drain in order, one per cycle.
- Flush with queue full and in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed and flush-cycle words never appear.
- With DECODE_ILLEGAL_CHECK_EN: 0x00000000 -> out_illegal=1, class 0; 0x40001033 (R, funct7 0100000, funct3 001) -> out_illegal=1; 0x40000033 (sub) -> out_illegal=0.
- Assert rst_n low mid-drain -> outputs 0 immediately, queue empty after release.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-issue handshake bundle for decode_stage.
// master drives instructions in and accepts bundles; slave is the decode stage.
interface decode_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic [5:0]      out_class;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_class, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_class, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: DEPTH-entry input queue feeding a registered decoded-bundle output.
// Optional illegal-instruction flagging is enabled with DECODE_ILLEGAL_CHECK_EN.
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    decode_stage_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [31:0]     mem_instr_q [DEPTH];
    logic [31:0]     mem_instr_d [DEPTH];
    logic [XLEN-1:0] mem_pc_q    [DEPTH];
    logic [XLEN-1:0] mem_pc_d    [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_ready_q, in_ready_d;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d, out_imm_q, out_imm_d;
    logic [6:0]      out_opcode_q, out_opcode_d, out_funct7_q, out_funct7_d;
    logic [4:0]      out_rd_q, out_rd_d, out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
    logic [2:0]      out_funct3_q, out_funct3_d;
    logic [5:0]      out_class_q, out_class_d;
    logic            out_illegal_q, out_illegal_d;

    logic            in_fire, q_empty, load_out, push, pop;
    logic [31:0]     src_instr;
    logic [XLEN-1:0] src_pc;

    // Handshake resolution; the input bypasses the queue only when it is empty.
    always_comb begin
        in_fire   = bus.in_valid && in_ready_q && !flush;
        q_empty   = (count_q == '0);
        load_out  = (!out_valid_q || bus.out_ready) && (!q_empty || in_fire) && !flush;
        pop       = load_out && !q_empty;
        push      = in_fire && !(load_out && q_empty);
        src_instr = q_empty ? bus.in_instr : mem_instr_q[rd_ptr_q];
        src_pc    = q_empty ? bus.in_pc    : mem_pc_q[rd_ptr_q];
    end

    logic        is_r, is_i, is_s, is_b, is_u, is_j;
    logic [4:0]  op5;
    logic [31:0] imm32;
    logic        dec_illegal;

    always_comb begin
        op5  = src_instr[6:2];
        is_r = (src_instr[1:0] == 2'b11) && (op5 == 5'b01100);
        is_i = (src_instr[1:0] == 2'b11) && ((op5 == 5'b00100) || (op5 == 5'b00000) ||
               (op5 == 5'b11001) || (op5 == 5'b00011) || (op5 == 5'b11100));
        is_s = (src_instr[1:0] == 2'b11) && (op5 == 5'b01000);
        is_b = (src_instr[1:0] == 2'b11) && (op5 == 5'b11000);
        is_u = (src_instr[1:0] == 2'b11) && ((op5 == 5'b01101) || (op5 == 5'b00101));
        is_j = (src_instr[1:0] == 2'b11) && (op5 == 5'b11011);

        imm32 = '0;
        if (is_i) imm32 = {{20{src_instr[31]}}, src_instr[31:20]};
        if (is_s) imm32 = {{20{src_instr[31]}}, src_instr[31:25], src_instr[11:7]};
        if (is_b) imm32 = {{19{src_instr[31]}}, src_instr[31], src_instr[7],
                           src_instr[30:25], src_instr[11:8], 1'b0};
        if (is_u) imm32 = {src_instr[31:12], 12'b0};
        if (is_j) imm32 = {{11{src_instr[31]}}, src_instr[31], src_instr[19:12],
                           src_instr[20], src_instr[30:21], 1'b0};
    end

`ifdef DECODE_ILLEGAL_CHECK_EN
    logic [2:0] chk_f3;
    logic [6:0] chk_f7;

    always_comb begin
        chk_f3      = src_instr[14:12];
        chk_f7      = src_instr[31:25];
        dec_illegal = !(is_r || is_i || is_s || is_b || is_u || is_j);
        if (is_r && !((chk_f7 == 7'b0000000) ||
                      ((chk_f7 == 7'b0100000) && ((chk_f3 == 3'b000) || (chk_f3 == 3'b101)))))
            dec_illegal = 1'b1;
        if (is_i && (op5 == 5'b00000) &&
            ((chk_f3 == 3'b011) || (chk_f3 == 3'b110) || (chk_f3 == 3'b111)))
            dec_illegal = 1'b1;
        if (is_s && (chk_f3 > 3'b010)) dec_illegal = 1'b1;
        if (is_b && ((chk_f3 == 3'b010) || (chk_f3 == 3'b011))) dec_illegal = 1'b1;
        if (is_i && (op5 == 5'b11001) && (chk_f3 != 3'b000)) dec_illegal = 1'b1;
    end
`else
    assign dec_illegal = 1'b0;
`endif

    // Next-state for queue, pointers and the output bundle register.
    always_comb begin
        mem_instr_d   = mem_instr_q;
        mem_pc_d      = mem_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_opcode_d  = out_opcode_q;
        out_rd_d      = out_rd_q;
        out_rs1_d     = out_rs1_q;
        out_rs2_d     = out_rs2_q;
        out_funct3_d  = out_funct3_q;
        out_funct7_d  = out_funct7_q;
        out_imm_d     = out_imm_q;
        out_class_d   = out_class_q;
        out_illegal_d = out_illegal_q;

        if (push) begin
            mem_instr_d[wr_ptr_q] = bus.in_instr;
            mem_pc_d[wr_ptr_q]    = bus.in_pc;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);

        if (load_out) begin
            out_valid_d   = 1'b1;
            out_pc_d      = src_pc;
            out_opcode_d  = src_instr[6:0];
            out_rd_d      = (is_r || is_i || is_u || is_j) ? src_instr[11:7] : 5'd0;
            out_rs1_d     = (is_r || is_i || is_s || is_b) ? src_instr[19:15] : 5'd0;
            out_rs2_d     = (is_r || is_s || is_b) ? src_instr[24:20] : 5'd0;
            out_funct3_d  = (is_r || is_i || is_s || is_b) ? src_instr[14:12] : 3'd0;
            out_funct7_d  = is_r ? src_instr[31:25] : 7'd0;
            out_imm_d     = XLEN'(signed'(imm32));
            out_class_d   = {is_r, is_i, is_s, is_b, is_u, is_j};
            out_illegal_d = dec_illegal;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end
        in_ready_d = (count_d < CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_instr_q   <= '{default: '0};
            mem_pc_q      <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_opcode_q  <= '0;
            out_rd_q      <= '0;
            out_rs1_q     <= '0;
            out_rs2_q     <= '0;
            out_funct3_q  <= '0;
            out_funct7_q  <= '0;
            out_imm_q     <= '0;
            out_class_q   <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            mem_instr_q   <= mem_instr_d;
            mem_pc_q      <= mem_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_opcode_q  <= out_opcode_d;
            out_rd_q      <= out_rd_d;
            out_rs1_q     <= out_rs1_d;
            out_rs2_q     <= out_rs2_d;
            out_funct3_q  <= out_funct3_d;
            out_funct7_q  <= out_funct7_d;
            out_imm_q     <= out_imm_d;
            out_class_q   <= out_class_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_opcode  = out_opcode_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.out_rs1     = out_rs1_q;
    assign bus.out_rs2     = out_rs2_q;
    assign bus.out_funct3  = out_funct3_q;
    assign bus.out_funct7  = out_funct7_q;
    assign bus.out_imm     = out_imm_q;
    assign bus.out_class   = out_class_q;
    assign bus.out_illegal = out_illegal_q;
endmodule
